// File: rtl/spi_xfer_buffer_pkg.sv
// spi_xfer_buffer_pkg
// Shared types for the SPI transfer buffer slice.
// fifo_op_e names the four occupancy updates a FIFO can make in one cycle.
// Its encoding is {pop accepted, push accepted}.
package spi_xfer_buffer_pkg;

  typedef enum logic [1:0] {
    FIFO_IDLE = 2'b00,
    FIFO_PUSH = 2'b01,
    FIFO_POP  = 2'b10,
    FIFO_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/spi_xfer_buffer_if.sv
// spi_xfer_buffer_if
// Bundles the SPI-engine and processing-unit signals of spi_xfer_buffer.
//   master : the side that drives ready/data_in and the PU requests (engine + PU)
//   slave  : the buffer itself
// Signals:
//   ready, data_in         word boundary level and received word from SPI engine
//   data_out               next word to shift out
//   pu_wr, pu_wr_data      TX push request and data
//   pu_rd, pu_rd_data      RX pop request and first-word-fall-through head
//   rx_count, tx_count     FIFO occupancies
//   rx_overflow, tx_underflow, clr_flags   sticky error flags and their clear
interface spi_xfer_buffer_if #(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_SIZE   = 6
);
  localparam int CNT_WIDTH = $clog2(BUF_SIZE + 1);

  logic                  ready;
  logic [DATA_WIDTH-1:0] data_in;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  pu_wr;
  logic [DATA_WIDTH-1:0] pu_wr_data;
  logic                  pu_rd;
  logic [DATA_WIDTH-1:0] pu_rd_data;
  logic [CNT_WIDTH-1:0]  rx_count;
  logic [CNT_WIDTH-1:0]  tx_count;
  logic                  rx_overflow;
  logic                  tx_underflow;
  logic                  clr_flags;

  modport master (
    output ready, data_in, pu_wr, pu_wr_data, pu_rd, clr_flags,
    input  data_out, pu_rd_data, rx_count, tx_count, rx_overflow, tx_underflow
  );

  modport slave (
    input  ready, data_in, pu_wr, pu_wr_data, pu_rd, clr_flags,
    output data_out, pu_rd_data, rx_count, tx_count, rx_overflow, tx_underflow
  );
endinterface

// File: rtl/spi_xfer_buffer_fifo.sv
// spi_fifo
// Circular word FIFO with a separate occupancy counter; depth need not be a
// power of two, so the pointers wrap explicitly at BUF_SIZE-1.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   push, push_data   write request and data
//   pop               read request (ignored when empty)
//   head              word at the read pointer (first-word-fall-through)
//   count             occupancy 0..BUF_SIZE
//   full, empty       occupancy status
// A push while full is accepted only if a pop is accepted in the same cycle.
// A pop while empty is dropped even if a push arrives (no bypass).
module spi_fifo
  import spi_xfer_buffer_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int BUF_SIZE   = 6
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           push,
  input  logic [DATA_WIDTH-1:0]          push_data,
  input  logic                           pop,
  output logic [DATA_WIDTH-1:0]          head,
  output logic [$clog2(BUF_SIZE+1)-1:0]  count,
  output logic                           full,
  output logic                           empty
);
  localparam int ADDR_WIDTH = $clog2(BUF_SIZE);
  localparam int CNT_WIDTH  = $clog2(BUF_SIZE + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_PTR = ADDR_WIDTH'(BUF_SIZE - 1);
  localparam logic [CNT_WIDTH-1:0]  MAX_CNT  = CNT_WIDTH'(BUF_SIZE);

  logic [DATA_WIDTH-1:0] r_mem [BUF_SIZE];
  logic [ADDR_WIDTH-1:0] r_wr_ptr;
  logic [ADDR_WIDTH-1:0] r_rd_ptr;
  logic [CNT_WIDTH-1:0]  r_count;

  logic     w_do_pop;
  logic     w_do_push;
  fifo_op_e w_op;

  assign empty     = (r_count == '0);
  assign full      = (r_count == MAX_CNT);
  assign w_do_pop  = pop & ~empty;
  assign w_do_push = push & (~full | w_do_pop);
  assign w_op      = fifo_op_e'({w_do_pop, w_do_push});

  assign head  = r_mem[r_rd_ptr];
  assign count = r_count;

  // Storage is deliberately left unreset; only pointers and count clear.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= push_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= (r_wr_ptr == LAST_PTR) ? '0 : r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= (r_rd_ptr == LAST_PTR) ? '0 : r_rd_ptr + 1'b1;
      end
      case (w_op)
        FIFO_PUSH: r_count <= r_count + 1'b1;
        FIFO_POP:  r_count <= r_count - 1'b1;
        default:   r_count <= r_count;
      endcase
    end
  end
endmodule

// File: rtl/spi_xfer_buffer.sv
// spi_xfer_buffer
// Two independent FIFOs between the SPI byte engine and the PU:
//   RX: SPI -> PU (pushed on each word boundary, popped by pu_rd)
//   TX: PU -> SPI (pushed by pu_wr, popped on each word boundary)
// Ports:
//   clk   system clock (rising edge)
//   rst   asynchronous active-high reset
//   bus   spi_xfer_buffer_if.slave: ready/data_in/data_out toward the SPI
//         engine, pu_* requests, counts and sticky flags toward the PU.
// Handshake: ready is a level that may stay high for several cycles; exactly
// one transfer happens on the first clock where ready is seen high after being
// low. pu_wr/pu_rd are single-cycle requests acted on at every clock where high;
// no acknowledge is returned, the counts tell the PU whether it took effect.
module spi_xfer_buffer #(
  parameter int                    DATA_WIDTH = 8,
  parameter int                    BUF_SIZE   = 6,
  parameter logic [DATA_WIDTH-1:0] FILL       = '0
) (
  input logic               clk,
  input logic               rst,
  spi_xfer_buffer_if.slave  bus
);
  logic                  r_ready_d;
  logic [DATA_WIDTH-1:0] r_data_out;
  logic                  r_rx_overflow;
  logic                  r_tx_underflow;

  logic                  w_xfer;
  logic                  w_rx_full;
  logic                  w_rx_empty_unused;
  logic                  w_tx_empty;
  logic                  w_tx_full_unused;
  logic [DATA_WIDTH-1:0] w_tx_head;
  logic                  w_ovf_set;
  logic                  w_unf_set;

  assign w_xfer = bus.ready & ~r_ready_d;

  // A full RX still accepts the word if the PU frees a slot this cycle.
  assign w_ovf_set = w_xfer & w_rx_full & ~bus.pu_rd;
  // An empty TX underflows even if the PU writes in the same cycle.
  assign w_unf_set = w_xfer & w_tx_empty;

  spi_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_SIZE   (BUF_SIZE)
  ) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (w_xfer),
    .push_data (bus.data_in),
    .pop       (bus.pu_rd),
    .head      (bus.pu_rd_data),
    .count     (bus.rx_count),
    .full      (w_rx_full),
    .empty     (w_rx_empty_unused)
  );

  spi_fifo #(
    .DATA_WIDTH (DATA_WIDTH),
    .BUF_SIZE   (BUF_SIZE)
  ) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (bus.pu_wr),
    .push_data (bus.pu_wr_data),
    .pop       (w_xfer),
    .head      (w_tx_head),
    .count     (bus.tx_count),
    .full      (w_tx_full_unused),
    .empty     (w_tx_empty)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ready_d      <= 1'b0;
      r_data_out     <= FILL;
      r_rx_overflow  <= 1'b0;
      r_tx_underflow <= 1'b0;
    end else begin
      r_ready_d <= bus.ready;
      if (w_xfer) begin
        r_data_out <= w_tx_empty ? FILL : w_tx_head;
      end
      // Set has priority over clear so an error in the clearing cycle survives.
      if (w_ovf_set) begin
        r_rx_overflow <= 1'b1;
      end else if (bus.clr_flags) begin
        r_rx_overflow <= 1'b0;
      end
      if (w_unf_set) begin
        r_tx_underflow <= 1'b1;
      end else if (bus.clr_flags) begin
        r_tx_underflow <= 1'b0;
      end
    end
  end

  assign bus.data_out     = r_data_out;
  assign bus.rx_overflow  = r_rx_overflow;
  assign bus.tx_underflow = r_tx_underflow;
endmodule

// File: tb/tb_spi_xfer_buffer.sv
// tb_spi_xfer_buffer
// Drives spi_xfer_buffer through directed scenarios and a random phase.
// A queue-based reference model predicts every data_out word and every popped
// RX word; a negedge monitor compares them as the DUT presents them.
module tb_spi_xfer_buffer;
  localparam int DW = 8;
  localparam int BS = 6;
  localparam logic [DW-1:0] FILL_W = 8'h00;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spi_xfer_buffer_if #(.DATA_WIDTH(DW), .BUF_SIZE(BS)) bus ();

  spi_xfer_buffer #(
    .DATA_WIDTH (DW),
    .BUF_SIZE   (BS),
    .FILL       (FILL_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- scoreboard state ----------------
  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];     // expected data_out words, one per transfer
  logic [DW-1:0] exp_rd_q[$];  // expected pu_rd_data at each accepted pop
  logic [DW-1:0] rx_m[$];      // model RX contents
  logic [DW-1:0] tx_m[$];      // model TX contents
  bit m_ovf, m_unf, m_ready_d;
  bit exp_xfer, rd_expect, pend_xfer;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Applies one cycle of inputs and advances the model to the state after the
  // next rising edge.
  task automatic drive_model(input bit rdy, input logic [DW-1:0] din, input bit wr,
                             input logic [DW-1:0] wd, input bit rd, input bit clr);
    bit xfer, pop_ok, ovf_set, unf_set;
    bus.ready      = rdy;
    bus.data_in    = din;
    bus.pu_wr      = wr;
    bus.pu_wr_data = wd;
    bus.pu_rd      = rd;
    bus.clr_flags  = clr;
    xfer      = rdy && !m_ready_d;
    m_ready_d = rdy;
    exp_xfer  = xfer;
    // RX: pop first so a full FIFO with a same-cycle read still accepts.
    pop_ok    = rd && (rx_m.size() > 0);
    rd_expect = pop_ok;
    if (pop_ok) exp_rd_q.push_back(rx_m.pop_front());
    ovf_set = 1'b0;
    if (xfer) begin
      if (rx_m.size() < BS) rx_m.push_back(din);
      else ovf_set = 1'b1;
    end
    // TX: the SPI pop sees the pre-push contents.
    unf_set = 1'b0;
    if (xfer) begin
      if (tx_m.size() > 0) exp_q.push_back(tx_m.pop_front());
      else begin
        exp_q.push_back(FILL_W);
        unf_set = 1'b1;
      end
    end
    if (wr && (tx_m.size() < BS)) tx_m.push_back(wd);
    m_ovf = ovf_set ? 1'b1 : (clr ? 1'b0 : m_ovf);
    m_unf = unf_set ? 1'b1 : (clr ? 1'b0 : m_unf);
  endtask

  // ---------------- driver tasks ----------------
  task automatic cycle(input bit rdy, input logic [DW-1:0] din, input bit wr,
                       input logic [DW-1:0] wd, input bit rd, input bit clr);
    @(posedge clk);
    #2;
    drive_model(rdy, din, wr, wd, rd, clr);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'($urandom), 0, 8'($urandom), 0, 0);
  endtask

  task automatic pulse(input logic [DW-1:0] din, input bit rd, input bit clr);
    cycle(1, din, 0, 8'h00, rd, clr);
    cycle(0, 8'($urandom), 0, 8'h00, 0, 0);
  endtask

  task automatic pu_write(input logic [DW-1:0] wd);
    cycle(0, 8'h00, 1, wd, 0, 0);
  endtask

  task automatic pu_read(input int n);
    for (int i = 0; i < n; i++) cycle(0, 8'h00, 0, 8'h00, 1, 0);
  endtask

  // Compares occupancy and flags just after the edge, then idles one cycle.
  task automatic check_state(input string tag);
    @(posedge clk);
    #1;
    check({tag, ".rx_count"}, 32'(bus.rx_count), 32'(rx_m.size()));
    check({tag, ".tx_count"}, 32'(bus.tx_count), 32'(tx_m.size()));
    check({tag, ".rx_overflow"}, 32'(bus.rx_overflow), 32'(m_ovf));
    check({tag, ".tx_underflow"}, 32'(bus.tx_underflow), 32'(m_unf));
    if (rx_m.size() > 0) check({tag, ".rx_head"}, 32'(bus.pu_rd_data), 32'(rx_m[0]));
    #1;
    drive_model(0, 8'h00, 0, 8'h00, 0, 0);
  endtask

  task automatic model_clear();
    exp_q.delete();
    exp_rd_q.delete();
    rx_m.delete();
    tx_m.delete();
    m_ovf = 0; m_unf = 0; m_ready_d = 0;
    exp_xfer = 0; rd_expect = 0;
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    if (rst) begin
      pend_xfer = 1'b0;
    end else begin
      if (pend_xfer) begin
        if (exp_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL data_out: transfer with no expected word at %0t", $time);
        end else begin
          check("data_out", 32'(bus.data_out), 32'(exp_q.pop_front()));
        end
      end
      if (rd_expect && bus.pu_rd) begin
        if (exp_rd_q.size() == 0) begin
          errors++; checks++;
          $display("FAIL pu_rd_data: pop with no expected word at %0t", $time);
        end else begin
          check("pu_rd_data", 32'(bus.pu_rd_data), 32'(exp_rd_q.pop_front()));
        end
      end
      pend_xfer = exp_xfer;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    model_clear();
    bus.ready = 0; bus.data_in = '0; bus.pu_wr = 0; bus.pu_wr_data = '0;
    bus.pu_rd = 0; bus.clr_flags = 0;
    #3;
    check("reset.data_out", 32'(bus.data_out), 32'(FILL_W));
    check("reset.rx_count", 32'(bus.rx_count), 0);
    check("reset.tx_count", 32'(bus.tx_count), 0);
    check("reset.flags", {30'd0, bus.rx_overflow, bus.tx_underflow}, 0);
    @(posedge clk); #2; rst = 1'b0;
    idle(2);

    // TX basic: two words then FILL with underflow on the third pulse
    pu_write(8'h11);
    pu_write(8'h22);
    pulse(8'h01, 0, 0);
    pulse(8'h02, 0, 0);
    check_state("tx_basic_pre");
    pulse(8'h03, 0, 0);
    check_state("tx_basic");
    pu_read(3);
    cycle(0, 8'h00, 0, 8'h00, 0, 1);
    check_state("tx_basic_drain");

    // ready held high 5 cycles -> one push
    for (int i = 0; i < 5; i++) cycle(1, 8'hA5, 0, 8'h00, 0, 0);
    check_state("hold5");
    pu_read(1);
    cycle(0, 8'h00, 0, 8'h00, 0, 1);
    check_state("hold5_drain");

    // RX overflow: 7 words into a depth-6 FIFO
    for (int i = 1; i <= 7; i++) pulse(8'(i), 0, 0);
    check_state("overflow");
    pu_read(6);
    check_state("overflow_drain");
    cycle(0, 8'h00, 0, 8'h00, 0, 1);

    // Wrap-around: 20 push/pop pairs, count never above 1
    for (int i = 0; i < 20; i++) begin
      cycle(1, 8'($urandom), 0, 8'h00, 0, 0);
      check_state("wrap_push");
      pu_read(1);
    end
    check_state("wrap_end");
    cycle(0, 8'h00, 0, 8'h00, 0, 1);

    // Full RX with transfer and read in the same cycle
    for (int i = 0; i < BS; i++) pulse(8'h30 + 8'(i), 0, 0);
    cycle(0, 8'h00, 0, 8'h00, 0, 1);
    cycle(1, 8'h99, 0, 8'h00, 1, 0);
    check_state("full_rd_xfer");
    pu_read(BS);
    check_state("full_rd_drain");

    // Empty TX with write and transfer together -> FILL, then the written word
    cycle(1, 8'h44, 1, 8'h5A, 0, 0);
    check_state("tx_empty_wr_xfer");
    pulse(8'h45, 0, 0);
    check_state("tx_after");
    pu_read(2);

    // Flag set in the same cycle as clr_flags survives
    for (int i = 0; i < BS; i++) pulse(8'h60 + 8'(i), 0, 0);
    cycle(1, 8'h66, 0, 8'h00, 0, 1);
    check_state("set_wins_clr");
    pu_read(BS);
    cycle(0, 8'h00, 0, 8'h00, 0, 1);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, 8'($urandom),
            $urandom_range(0, 2) != 0, 8'($urandom),
            $urandom_range(0, 2) == 0, $urandom_range(0, 15) == 0);
      if (i % 16 == 15) check_state("random");
    end
    pu_read(BS);
    check_state("random_drain");

    // Asynchronous reset mid-stream with 3 RX words and a non-FILL data_out
    pu_write(8'h77);
    pu_write(8'h78);
    pulse(8'hC1, 0, 0);
    pulse(8'hC2, 0, 0);
    pulse(8'hC3, 0, 0);
    check_state("pre_reset");
    idle(1);
    @(posedge clk); #3;
    rst = 1'b1;
    bus.ready = 0; bus.pu_wr = 0; bus.pu_rd = 0; bus.clr_flags = 0;
    #1;
    model_clear();
    check("async_rst.rx_count", 32'(bus.rx_count), 0);
    check("async_rst.tx_count", 32'(bus.tx_count), 0);
    check("async_rst.flags", {30'd0, bus.rx_overflow, bus.tx_underflow}, 0);
    check("async_rst.data_out", 32'(bus.data_out), 32'(FILL_W));
    @(posedge clk); #2; rst = 1'b0;
    check_state("post_reset");
    pu_write(8'hB4);
    pulse(8'hD1, 0, 0);
    check_state("post_reset_op");
    pu_read(1);
    idle(3);

    check("final.exp_q_empty", 32'(exp_q.size()), 0);
    check("final.exp_rd_q_empty", 32'(exp_rd_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
